// File: rtl/regfile_access_ctrl.sv
// Host byte/halfword access controller for the 28x32 register file; sub-word writes run as read-modify-write.
// Optional out-of-range index rejection: define REGFILE_ACC_RANGE_CHK_EN.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int REG_COUNT  = 28,
    localparam int IDX_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rf_rw,
    output logic [IDX_W-1:0]      rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic                    r_rf_rw;
    logic [IDX_W-1:0]        r_rf_addr;
    logic [15:0]             r_rdata;
    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_wdata;
    logic [DATA_WIDTH-1:0]   r_word;
    logic                    w_accept;
    logic                    w_oor;
    logic [IDX_W-1:0]        w_idx;

    // Address fields: [7] halfword, [6:5] byte lane, [5] alone picks the half.
    function automatic logic [15:0] extract(input logic [DATA_WIDTH-1:0] word,
                                            input logic [ADDR_WIDTH-1:0] addr);
        logic [15:0] field;
        if (addr[7]) field = addr[5] ? word[31:16] : word[15:0];
        else         field = {8'h00, word[8*addr[6:5] +: 8]};
        return field;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic [15:0]           wdata);
        logic [DATA_WIDTH-1:0] m;
        m = word;
        if (addr[7]) m[16*addr[5] +: 16] = wdata;
        else         m[8*addr[6:5] +: 8] = wdata[7:0];
        return m;
    endfunction

    assign w_accept = r_req_ready && req_valid;
    assign w_idx    = (r_state == IDLE) ? req_addr[IDX_W-1:0] : r_addr[IDX_W-1:0];

`ifdef REGFILE_ACC_RANGE_CHK_EN
    logic r_err;

    assign w_oor = int'(req_addr[IDX_W-1:0]) >= REG_COUNT;

    always_ff @(posedge clk) begin
        if (!rst_n)        r_err <= 1'b0;
        else if (w_accept) r_err <= w_oor;
    end

    assign rsp_err = r_err;
`else
    assign w_oor   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = w_oor ? RESP : RD;
            RD:      w_next = CAP;
            CAP:     w_next = r_wr ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and register-file controls are registered from the next state, so rf_rw cannot glitch low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rf_rw     <= 1'b1;
            r_rf_addr   <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            r_rf_rw     <= (w_next != WR);
            r_rf_addr   <= (w_next == IDLE) ? '0 : w_idx;
            if (w_accept)                     r_rdata <= '0;
            else if (r_state == CAP && !r_wr) r_rdata <= extract(rf_rdata, r_addr);
        end
    end

    // NOTE: request and word registers are qualified by the FSM and need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
        if (r_state == CAP) r_word <= rf_rdata;
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rf_rw     = r_rf_rw;
    assign rf_addr   = r_rf_addr;
    assign rf_wdata  = (r_state == WR) ? merge(r_word, r_addr, r_wdata) : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: register-file model, response scoreboard, write monitor.
// Range-check expectations follow REGFILE_ACC_RANGE_CHK_EN.
module tb_regfile_access_ctrl;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rf_rw;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    logic [31:0] rf_mem [32];
    logic        ld_en;
    logic [4:0]  ld_idx;
    logic [31:0] ld_val;

    int          mon_wr_count = 0;
    logic [31:0] mon_wdata;
    logic [4:0]  mon_waddr;

    rsp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    regfile_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rf_rw     (rf_rw),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: writes whenever rf_rw is low, read data one cycle after the address.
    always @(posedge clk) begin
        if (ld_en)               rf_mem[ld_idx] <= ld_val;
        else if (rf_rw === 1'b0) rf_mem[rf_addr] <= rf_wdata;
        rf_rdata <= rf_mem[rf_addr];
    end

    always @(negedge clk) begin
        if (rf_rw === 1'b0) begin
            mon_wr_count <= mon_wr_count + 1;
            mon_wdata    <= rf_wdata;
            mon_waddr    <= rf_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_writes,
                          input logic [4:0] exp_waddr, input logic [31:0] exp_wdata,
                          input int hold);
        int   wr0;
        int   lat;
        rsp_t exp_rsp;
        @(negedge clk);
        check({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        wr0       = mon_wr_count;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/req_ready_busy"}, 32'(req_ready), 32'd0);
        exp_rsp = sb.pop_front();
        check({tag, "/rdata"}, 32'(rsp_rdata), 32'(exp_rsp.rdata));
        check({tag, "/err"}, 32'(rsp_err), 32'(exp_rsp.err));
        repeat (hold) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, 32'(rsp_rdata), 32'(exp_rsp.rdata));
            check({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_rsp.err));
            check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "/rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, "/req_ready_back"}, 32'(req_ready), 32'd1);
        check({tag, "/write_cycles"}, 32'(mon_wr_count - wr0), 32'(exp_writes));
        if (exp_writes > 0) begin
            check({tag, "/wdata"}, mon_wdata, exp_wdata);
            check({tag, "/waddr"}, 32'(mon_waddr), 32'(exp_waddr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        rsp_ready = 1'b1;
        ld_en     = 1'b0;
        ld_idx    = 5'd0;
        ld_val    = 32'h0;

        poke(5'd3,  32'hA1B2C3D4);
        poke(5'd5,  32'h11223344);
        poke(5'd0,  32'hFFFFFFFF);
        poke(5'd7,  32'h0BADF00D);
        poke(5'd29, 32'h55667788);

        @(negedge clk);
        check("rst/req_ready", 32'(req_ready), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/rf_rw", 32'(rf_rw), 32'd1);
        check("rst/rf_addr", 32'(rf_addr), 32'd0);
        check("rst/rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel/req_ready", 32'(req_ready), 32'd1);

        do_req("rd_b3_l3", 1'b0, 8'h63, 16'h0000, 16'h00A1, 1'b0, 3, 0, 5'd0, 32'h0, 0);
        do_req("wr_h5_hi", 1'b1, 8'hA5, 16'hBEEF, 16'h0000, 1'b0, 4, 1, 5'd5, 32'hBEEF3344, 0);
        do_req("wr_b0_l1", 1'b1, 8'h20, 16'h0012, 16'h0000, 1'b0, 4, 1, 5'd0, 32'hFFFF12FF, 0);
        do_req("rd_h0_lo", 1'b0, 8'h80, 16'h0000, 16'h12FF, 1'b0, 3, 0, 5'd0, 32'h0, 0);
        do_req("bp_h5_lo", 1'b0, 8'hC5, 16'h0000, 16'h3344, 1'b0, 3, 0, 5'd0, 32'h0, 10);
        do_req("rd_h5_hi", 1'b0, 8'hA5, 16'h0000, 16'hBEEF, 1'b0, 3, 0, 5'd0, 32'h0, 0);
        do_req("rd_b7_l2", 1'b0, 8'h47, 16'h0000, 16'h00AD, 1'b0, 3, 0, 5'd0, 32'h0, 0);
        do_req("wr_b7_l0", 1'b1, 8'h07, 16'hAB12, 16'h0000, 1'b0, 4, 1, 5'd7, 32'h0BADF012, 0);
        do_req("rd_b7_l0", 1'b0, 8'h07, 16'h0000, 16'h0012, 1'b0, 3, 0, 5'd0, 32'h0, 0);

`ifdef REGFILE_ACC_RANGE_CHK_EN
        do_req("oor_wr29", 1'b1, 8'h1D, 16'h00CC, 16'h0000, 1'b1, 1, 0, 5'd0, 32'h0, 0);
        do_req("oor_rd29", 1'b0, 8'h9D, 16'h0000, 16'h0000, 1'b1, 1, 0, 5'd0, 32'h0, 3);
`else
        do_req("rmw_wr29", 1'b1, 8'h1D, 16'h00CC, 16'h0000, 1'b0, 4, 1, 5'd29, 32'h556677CC, 0);
        do_req("rmw_rd29", 1'b0, 8'h9D, 16'h0000, 16'h77CC, 1'b0, 3, 0, 5'd0, 32'h0, 3);
`endif

        // Reset lands on the edge that ends the single write cycle.
        @(negedge clk);
        wr0       = mon_wr_count;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h03;
        req_wdata = 16'h0077;
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midwr/rf_rw_low", 32'(rf_rw), 32'd0);
        check("midwr/rf_wdata", rf_wdata, 32'hA1B2C377);
        check("midwr/rf_addr", 32'(rf_addr), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midwr/rst_rf_rw", 32'(rf_rw), 32'd1);
        check("midwr/rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midwr/rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midwr/rel_req_ready", 32'(req_ready), 32'd1);
        check("midwr/rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midwr/rel_rf_rw", 32'(rf_rw), 32'd1);
        check("midwr/write_cycles", 32'(mon_wr_count - wr0), 32'd1);

        do_req("rd_h3_lo", 1'b0, 8'h83, 16'h0000, 16'hC377, 1'b0, 3, 0, 5'd0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Host-side access controller sitting directly upstream of the 28×32-bit register file. It accepts 8/16-bit read and write requests over a valid/ready handshake and decodes the packed 8-bit address. Sub-word writes become read-modify-write sequences on the file's single `rf_rw`/`rf_addr` port, because that port only writes full 32-bit words. Read data returns zero-extended on a held response channel.

## Interface
- `DATA_WIDTH`, 32: register word width.
- `ADDR_WIDTH`, 8: packed host address width.
- `REG_COUNT`, 28: number of implemented registers.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 8: bits [4:0] register index; [6:5] byte lane; [7] width (0 = byte, 1 = halfword).
- `req_wdata` in 16: write data; byte mode uses [7:0].
- `rsp_valid` out 1: response present, held until accepted.
- `rsp_ready` in 1: host accepts the response.
- `rsp_rdata` out 16: read data, zero-extended; 0 for writes.
- `rsp_err` out 1: out-of-range index.
- `rf_rw` out 1: register-file control; 1 = read, 0 = write.
- `rf_addr` out 5: register index.
- `rf_wdata` out 32: full word to write.
- `rf_rdata` in 32: register-file read data, valid one cycle after the read is issued.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_wr`, `req_addr` and `req_wdata`.
  - Out-of-range index: go to RESP with error.
  - Otherwise: go to RD.
- RD: `rf_rw`=1 and `rf_addr`=latched index.
- CAP: capture `rf_rdata` into the word register.
  - Read request: extract the selected field, then go to RESP.
  - Write request: go to WR.
- Byte extraction: lane 0 = [7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24].
- Halfword extraction:
  - `req_addr[5]`=0 selects [15:0]; 1 selects [31:16].
  - `req_addr[6]` is ignored.
- WR:
  - `rf_rw`=0 for exactly one cycle.
  - `rf_wdata` = captured word with only the selected byte or halfword replaced by `req_wdata`; all other bits are preserved.
  - Then go to RESP.
- RESP: `rsp_valid`=1 with stable data; on `rsp_ready`, go to IDLE.
- `rf_rw` is 1 in every state except WR. The register file writes whenever `rf_rw`=0, so a glitch or extra WR cycle corrupts state.
- `rf_addr` holds the latched index outside IDLE and is 0 in IDLE.

## Timing
- Reset values: `req_ready`=0 during reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rf_rw`=1, `rf_addr`=0, `rf_wdata`=0. State is IDLE, so `req_ready`=1 on the first cycle after release.
- Latency from the accept edge:
  - Read: `rsp_valid` asserts 3 cycles later.
  - Write: `rsp_valid` asserts 4 cycles later.
  - Error: `rsp_valid` asserts 1 cycle later.
  - Each case assumes no response backpressure.
- Handshakes complete only when valid & ready are both high at a clock edge.
- `req_ready` is 0 in every state except IDLE. No request is accepted in the same cycle a response completes.
- `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant while `rsp_ready`=0, for any number of cycles.
- `rst_n` low at any edge, including mid-WR:
  - Next state is IDLE and `rf_rw` returns to 1.
  - No further register-file write occurs.
  - A pending response is dropped.
- Throughput: at most one transaction in flight.

## Configuration
- `REGFILE_ACC_RANGE_CHK_EN` defined:
  - Indices ≥ `REG_COUNT` (28–31) never touch the register file.
  - They respond with `rsp_err`=1 and `rsp_rdata`=0.
- Not defined:
  - `rsp_err` is tied 0.
  - All 32 indices follow the normal read/RMW path.

## Test plan
- Reset then byte read: reg 3 = 0xA1B2C3D4, `req_addr`=0x63 (lane 3) → `rsp_rdata`=0x00A1 at 3 cycles, `rsp_err`=0.
- Halfword write: reg 5 = 0x11223344, `req_addr`=0xA5 (halfword, upper half), `req_wdata`=0xBEEF → exactly one `rf_rw`=0 cycle with `rf_wdata`=0xBEEF3344; `rsp_valid` at 4 cycles.
- Byte write lane 1: reg 0 = 0xFFFFFFFF, `req_addr`=0x20, `req_wdata`=0x0012 → `rf_wdata`=0xFFFF12FF; a readback with `req_addr`=0x80 returns 0x12FF.
- Backpressure: hold `rsp_ready`=0 for 10 cycles → response stable, `req_ready`=0 throughout, no `rf_rw`=0 cycles.
- Range check (macro on): `req_addr`=0x1D write → `rsp_err`=1 one cycle after accept, `rf_rw` never 0; with the macro off → normal RMW on index 29.
- Reset mid-WR: drop `rst_n` in the WR cycle → next cycle `rf_rw`=1, `rsp_valid`=0, `req_ready`=1 after release.
